// File: rtl/pu_pkg.sv
// pu_pkg: shared PU datapath constants and register-file types.
package pu_pkg;
  localparam int PU_W = 16;
  localparam int PU_N = 4;
  typedef logic [$clog2(PU_N)-1:0] reg_addr_t;
  typedef logic [PU_W-1:0] data_t;
endpackage

// File: rtl/ra_scoreboard.sv
// ra_scoreboard: per-register busy bits with issue-over-writeback priority and per-port lookup.
module ra_scoreboard #(
  parameter int N  = 4,
  parameter int AW = $clog2(N),
  parameter int NR = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [AW-1:0]  wad,
  input  logic           iss,
  input  logic [AW-1:0]  iad,
  input  logic [NR*AW-1:0] rad,
  output logic [N-1:0]   busy,
  output logic [NR-1:0]  rbusy
);
  logic [N-1:0] busy_q, busy_d;
  // a same-cycle issue wins: the new producer supersedes the retiring one
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < N; i++)
      busy_d[i] = (iss && iad == AW'(i)) ? 1'b1 : (we && wad == AW'(i)) ? 1'b0 : busy_q[i];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  always_comb begin
    rbusy = '0;
    for (int k = 0; k < NR; k++) rbusy[k] = busy_q[rad[k*AW +: AW]];
  end
  assign busy = busy_q;
endmodule

// File: rtl/ra_multi.sv
// ra_multi: multi-port register array with busy scoreboard and write counter.
// Define RA_BYPASS_EN for combinational write-to-read forwarding.
module ra_multi
  import pu_pkg::*;
#(
  parameter int W  = PU_W,
  parameter int N  = PU_N,
  parameter int AW = $clog2(N),
  parameter int NR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] rad,
  output logic [NR*W-1:0]  rd,
  output logic [NR-1:0]    rbusy,
  input  logic             we,
  input  logic [AW-1:0]    wad,
  input  logic [W-1:0]     wd,
  input  logic             iss,
  input  logic [AW-1:0]    iad,
  output logic [N-1:0]     busy,
  output logic [15:0]      wcnt
);
  logic [W-1:0] regs_q [N];
  logic [15:0] wcnt_q;
  logic [NR-1:0] sb_rbusy;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      wcnt_q <= '0;
    end else if (we) begin
      regs_q[wad] <= wd;
      wcnt_q <= wcnt_q + 16'd1;
    end
  ra_scoreboard #(.N(N), .AW(AW), .NR(NR)) u_sb (
    .clk(clk), .rst(rst), .we(we), .wad(wad), .iss(iss), .iad(iad),
    .rad(rad), .busy(busy), .rbusy(sb_rbusy)
  );
  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rad[k*AW +: AW];
`ifdef RA_BYPASS_EN
    logic fwd;
    assign fwd = we && !rst && a == wad;
    assign rd[k*W +: W] = fwd ? wd : regs_q[a];
    assign rbusy[k] = fwd ? (iss && iad == wad) : sb_rbusy[k];
`else
    assign rd[k*W +: W] = regs_q[a];
    assign rbusy[k] = sb_rbusy[k];
`endif
  end
  assign wcnt = wcnt_q;
endmodule

// File: tb/tb_ra_multi.sv
// tb_ra_multi: directed and randomized checks of ra_multi against an array model.
module tb_ra_multi;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] rad;
  logic [31:0] rd;
  logic [1:0] rbusy;
  logic we, iss;
  logic [1:0] wad, iad;
  logic [15:0] wd;
  logic [3:0] busy;
  logic [15:0] wcnt;
  int n_chk = 0, n_pass = 0;
  logic [15:0] m_reg [4] = '{default: 16'h0};
  logic [3:0] m_busy = '0;
  logic [15:0] m_cnt = '0;

  ra_multi dut (
    .clk(clk), .rst(rst), .rad(rad), .rd(rd), .rbusy(rbusy), .we(we), .wad(wad),
    .wd(wd), .iss(iss), .iad(iad), .busy(busy), .wcnt(wcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // reference: plain register array, issue applied after writeback so it wins
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_reg <= '{default: 16'h0};
      m_busy <= '0;
      m_cnt <= '0;
    end else begin
      if (we) begin
        m_reg[wad] <= wd;
        m_busy[wad] <= 1'b0;
        m_cnt <= m_cnt + 16'd1;
      end
      if (iss) m_busy[iad] <= 1'b1;
    end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0] a;
      logic [15:0] erd;
      logic erb;
      a = rad[k*2 +: 2];
      erd = m_reg[a];
      erb = m_busy[a];
`ifdef RA_BYPASS_EN
      if (we && !rst && a == wad) begin
        erd = wd;
        erb = iss && iad == wad;
      end
`endif
      chk($sformatf("rd%0d", k), {16'h0, rd[k*16 +: 16]}, {16'h0, erd});
      chk($sformatf("rbusy%0d", k), {31'h0, rbusy[k]}, {31'h0, erb});
    end
    chk("busy", {28'h0, busy}, {28'h0, m_busy});
    chk("wcnt", {16'h0, wcnt}, {16'h0, m_cnt});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; iss = 0;
  endtask

  initial begin
    rst = 1; rad = '0; we = 0; wad = '0; wd = '0; iss = 0; iad = '0;
    tick(); tick();
    chk("reset busy", {28'h0, busy}, 32'h0);
    chk("reset wcnt", {16'h0, wcnt}, 32'h0);
    chk("reset rd", rd, 32'h0);
    rst = 0;
    we = 1; wad = 2; wd = 16'h1234;
    tick(); idle(); rad = {2'd2, 2'd2};
    #1 chk("reg2 write", rd, 32'h1234_1234);
    rst = 1;
    #1 chk("mid rst rd", rd, 32'h0);
    chk("mid rst wcnt", {16'h0, wcnt}, 32'h0);
    tick(); rst = 0;
    #1 chk("post rst rd", rd, 32'h0);
    we = 1; wad = 3; wd = 16'hBEEF;
    tick(); idle(); rad = {2'd3, 2'd3};
    #1 chk("beef rd", rd, 32'hBEEF_BEEF);
    chk("beef wcnt", {16'h0, wcnt}, 32'h1);
    iss = 1; iad = 1;
    tick(); idle(); rad = {2'd3, 2'd1};
    #1 chk("iss busy", {28'h0, busy}, 32'h2);
    chk("iss rbusy0", {31'h0, rbusy[0]}, 32'h1);
    tick(); tick();
    we = 1; wad = 1; wd = 16'h00AA;
    tick(); idle();
    #1 chk("wb busy", {28'h0, busy}, 32'h0);
    chk("wb rd0", {16'h0, rd[15:0]}, 32'h00AA);
    iss = 1; iad = 2;
    tick();
    we = 1; wad = 2; wd = 16'h5555; iss = 1; iad = 2;
    tick(); idle(); rad = {2'd3, 2'd2};
    #1 chk("same addr rd", {16'h0, rd[15:0]}, 32'h5555);
    chk("same addr busy", {28'h0, busy}, 32'h4);
    we = 1; wad = 0; wd = 16'h0001;
    tick();
    we = 1; wad = 0; wd = 16'h7777; rad = {2'd3, 2'd0};
`ifdef RA_BYPASS_EN
    #1 chk("pre-edge rd0", {16'h0, rd[15:0]}, 32'h7777);
`else
    #1 chk("pre-edge rd0", {16'h0, rd[15:0]}, 32'h0001);
`endif
    tick(); idle();
    #1 chk("post-edge rd0", {16'h0, rd[15:0]}, 32'h7777);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) == 0);
      we = $urandom_range(1); wad = 2'($urandom); wd = 16'($urandom);
      iss = $urandom_range(1); iad = 2'($urandom); rad = 4'($urandom);
      tick();
    end
    rst = 1; idle();
    tick(); rst = 0;
    for (int i = 0; i < 65536; i++) begin
      we = 1; wad = 2'(i); wd = 16'(i); rad = 4'($urandom);
      tick();
    end
    idle(); rad = {2'd3, 2'd0};
    #1 chk("wrap wcnt", {16'h0, wcnt}, 32'h0);
    chk("wrap regs", rd, 32'hFFFF_FFFC);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
